// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoder control and ID operands, detects
// load-use hazards against EX, inserts bubbles on hazard or flush, counts bubbles.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic              id_jump,
    input  logic              id_RegWr,
    input  logic              id_MemtoReg,
    input  logic              id_MemWr,
    input  logic              id_ALUsrc,
    input  logic              id_RegDst,
    input  logic              id_Branch,
    input  logic [1:0]        id_ALUopc,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic              flush,
    output logic              stall,
    output logic              ex_valid,
    output logic              ex_jump,
    output logic              ex_RegWr,
    output logic              ex_MemtoReg,
    output logic              ex_MemWr,
    output logic              ex_ALUsrc,
    output logic              ex_RegDst,
    output logic              ex_Branch,
    output logic [1:0]        ex_ALUopc,
    output logic [DATA_W-1:0] ex_rd1,
    output logic [DATA_W-1:0] ex_rd2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [REG_W-1:0]  ex_rs,
    output logic [REG_W-1:0]  ex_rt,
    output logic [REG_W-1:0]  ex_rd,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic              ex_valid_reg;
    logic              ex_jump_reg;
    logic              ex_RegWr_reg;
    logic              ex_MemtoReg_reg;
    logic              ex_MemWr_reg;
    logic              ex_ALUsrc_reg;
    logic              ex_RegDst_reg;
    logic              ex_Branch_reg;
    logic [1:0]        ex_ALUopc_reg;
    logic [DATA_W-1:0] ex_rd1_reg;
    logic [DATA_W-1:0] ex_rd2_reg;
    logic [DATA_W-1:0] ex_imm_reg;
    logic [DATA_W-1:0] ex_pc4_reg;
    logic [REG_W-1:0]  ex_rs_reg;
    logic [REG_W-1:0]  ex_rt_reg;
    logic [REG_W-1:0]  ex_rd_reg;
    logic [CNT_W-1:0]  bubble_cnt_reg;
    logic [CNT_W-1:0]  bubble_cnt_next;

    logic id_uses_rt;
    logic ex_is_load;
    logic hazard;
    logic load_bubble;

    // rt is a source only for R-type, stores and branches
    assign id_uses_rt = id_RegDst | id_MemWr | id_Branch;
    assign ex_is_load = ex_valid_reg & ex_MemtoReg_reg & ex_RegWr_reg & (ex_rt_reg != '0);
    assign hazard     = id_valid & ex_is_load &
                        ((ex_rt_reg == id_rs) | (id_uses_rt & (ex_rt_reg == id_rt)));
    assign stall       = hazard & ~flush & ~rst;
    assign load_bubble = flush | hazard;

    assign bubble_cnt_next = (bubble_cnt_reg == CNT_MAX) ? bubble_cnt_reg
                                                         : bubble_cnt_reg + 1'b1;

    // A bubble clears data and specifiers too, so it never matches a forwarding compare
    always_ff @(posedge clk) begin
        if (rst || load_bubble) begin
            ex_valid_reg    <= 1'b0;
            ex_jump_reg     <= 1'b0;
            ex_RegWr_reg    <= 1'b0;
            ex_MemtoReg_reg <= 1'b0;
            ex_MemWr_reg    <= 1'b0;
            ex_ALUsrc_reg   <= 1'b0;
            ex_RegDst_reg   <= 1'b0;
            ex_Branch_reg   <= 1'b0;
            ex_ALUopc_reg   <= '0;
            ex_rd1_reg      <= '0;
            ex_rd2_reg      <= '0;
            ex_imm_reg      <= '0;
            ex_pc4_reg      <= '0;
            ex_rs_reg       <= '0;
            ex_rt_reg       <= '0;
            ex_rd_reg       <= '0;
        end else begin
            ex_valid_reg    <= id_valid;
            ex_jump_reg     <= id_jump;
            ex_RegWr_reg    <= id_RegWr;
            ex_MemtoReg_reg <= id_MemtoReg;
            ex_MemWr_reg    <= id_MemWr;
            ex_ALUsrc_reg   <= id_ALUsrc;
            ex_RegDst_reg   <= id_RegDst;
            ex_Branch_reg   <= id_Branch;
            ex_ALUopc_reg   <= id_ALUopc;
            ex_rd1_reg      <= id_rd1;
            ex_rd2_reg      <= id_rd2;
            ex_imm_reg      <= id_imm;
            ex_pc4_reg      <= id_pc4;
            ex_rs_reg       <= id_rs;
            ex_rt_reg       <= id_rt;
            ex_rd_reg       <= id_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt_reg <= '0;
        end else if (load_bubble) begin
            bubble_cnt_reg <= bubble_cnt_next;
        end
    end

    assign ex_valid    = ex_valid_reg;
    assign ex_jump     = ex_jump_reg;
    assign ex_RegWr    = ex_RegWr_reg;
    assign ex_MemtoReg = ex_MemtoReg_reg;
    assign ex_MemWr    = ex_MemWr_reg;
    assign ex_ALUsrc   = ex_ALUsrc_reg;
    assign ex_RegDst   = ex_RegDst_reg;
    assign ex_Branch   = ex_Branch_reg;
    assign ex_ALUopc   = ex_ALUopc_reg;
    assign ex_rd1      = ex_rd1_reg;
    assign ex_rd2      = ex_rd2_reg;
    assign ex_imm      = ex_imm_reg;
    assign ex_pc4      = ex_pc4_reg;
    assign ex_rs       = ex_rs_reg;
    assign ex_rt       = ex_rt_reg;
    assign ex_rd       = ex_rd_reg;
    assign bubble_cnt  = bubble_cnt_reg;

endmodule
